// File: rtl/fma16_pkg.sv
// fma16_pkg: shared opcode/rounding types, FP16 constants and opcode decode
package fma16_pkg;
    typedef enum logic [2:0] {
        OP_FADD    = 3'b000,
        OP_FSUB    = 3'b001,
        OP_FMUL    = 3'b010,
        OP_FMADD   = 3'b011,
        OP_FMSUB   = 3'b100,
        OP_FNMADD  = 3'b101,
        OP_FNMSUB  = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_t;
    typedef enum logic [1:0] {RM_RZ, RM_RNE, RM_RP, RM_RN} rm_t;
    typedef struct packed {
        logic mul;
        logic add;
        logic negr;
        logic negz;
    } ctrl_t;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        ctrl_t       ctrl;
        rm_t         rm;
    } entry_t;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    function automatic ctrl_t decode(input op_t op);
        case (op)
            OP_FADD:   return ctrl_t'(4'b0100);
            OP_FSUB:   return ctrl_t'(4'b0101);
            OP_FMUL:   return ctrl_t'(4'b1000);
            OP_FMADD:  return ctrl_t'(4'b1100);
            OP_FMSUB:  return ctrl_t'(4'b1101);
            OP_FNMADD: return ctrl_t'(4'b1110);
            OP_FNMSUB: return ctrl_t'(4'b1111);
            default:   return ctrl_t'(4'b0000);
        endcase
    endfunction
endpackage

// File: rtl/fma16_issue_fifo.sv
// fma16_issue_fifo: synchronous FIFO whose head output holds the last popped word when empty
module fma16_issue_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_last;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;
    assign w_wr    = wr_en && r_count != FULL;
    assign w_rd    = rd_en && r_count != '0;
    assign count   = r_count;
    assign rd_data = r_count != '0 ? r_mem[r_rd_ptr] : r_last;
    // storage array needs no reset: it is only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end
    // pointers, occupancy and the word shown while empty
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            r_wr_ptr <= w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_rd ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count  <= r_count + CW'(w_wr) - CW'(w_rd);
            r_last   <= w_rd ? r_mem[r_rd_ptr] : r_last;
        end
    end
endmodule

// File: rtl/fma16_issue.sv
// fma16_issue: FP16 FMA issue stage (decode, canonicalise, buffer); optional stats via FMA16_ISSUE_STATS_EN
module fma16_issue
    import fma16_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [15:0]   in_x,
    input  logic [15:0]   in_y,
    input  logic [15:0]   in_z,
    input  logic [1:0]    in_rm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_x,
    output logic [15:0]   out_y,
    output logic [15:0]   out_z,
    output logic          out_mul,
    output logic          out_add,
    output logic          out_negr,
    output logic          out_negz,
    output logic [1:0]    out_rm,
    output logic [CW-1:0] count,
    output logic          err_illegal,
    output logic [15:0]   issued_cnt,
    output logic [15:0]   stall_cnt
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    ctrl_t  w_ctrl;
    entry_t w_in;
    entry_t w_head;
    logic   w_illegal;
    logic   w_acc;
    logic   w_deq;
    logic   r_err;
    assign w_ctrl    = decode(op_t'(in_op));
    assign w_illegal = in_op == OP_ILLEGAL;
    assign in_ready  = count != FULL;
    assign out_valid = count != '0;
    assign w_acc     = in_valid && in_ready;
    assign w_deq     = out_valid && out_ready;
    assign w_in.x    = in_x;
    assign w_in.y    = w_ctrl.mul ? in_y : FP16_ONE;
    assign w_in.z    = w_ctrl.add ? in_z : FP16_ZERO;
    assign w_in.ctrl = w_ctrl;
    assign w_in.rm   = rm_t'(in_rm);
    fma16_issue_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_acc && !w_illegal),
        .wr_data (w_in),
        .rd_en   (w_deq),
        .rd_data (w_head),
        .count   (count)
    );
    assign out_x       = w_head.x;
    assign out_y       = w_head.y;
    assign out_z       = w_head.z;
    assign out_mul     = w_head.ctrl.mul;
    assign out_add     = w_head.ctrl.add;
    assign out_negr    = w_head.ctrl.negr;
    assign out_negz    = w_head.ctrl.negz;
    assign out_rm      = w_head.rm;
    assign err_illegal = r_err;
    // sticky flag for accepted-but-dropped illegal opcodes
    always_ff @(posedge clk) begin
        r_err <= reset ? 1'b0 : r_err | (w_acc && w_illegal);
    end
`ifdef FMA16_ISSUE_STATS_EN
    logic [15:0] r_issued;
    logic [15:0] r_stall;
    // issued count wraps; stall count saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued <= '0;
            r_stall  <= '0;
        end else begin
            r_issued <= w_deq ? r_issued + 16'd1 : r_issued;
            r_stall  <= (in_valid && !in_ready && r_stall != 16'hFFFF) ? r_stall + 16'd1 : r_stall;
        end
    end
    assign issued_cnt = r_issued;
    assign stall_cnt  = r_stall;
`else
    assign issued_cnt = 16'h0000;
    assign stall_cnt  = 16'h0000;
`endif
endmodule

// File: tb/tb_fma16_issue.sv
// tb_fma16_issue: directed plus randomized checks of fma16_issue against a queue-based model
module tb_fma16_issue;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [3:0]  c;
        logic [1:0]  rm;
    } ent_t;
    logic          clk = 0;
    logic          reset = 1;
    logic          in_valid = 0;
    logic          in_ready;
    logic [2:0]    in_op = 0;
    logic [15:0]   in_x = 0, in_y = 0, in_z = 0;
    logic [1:0]    in_rm = 0;
    logic          out_valid;
    logic          out_ready = 0;
    logic [15:0]   out_x, out_y, out_z;
    logic          out_mul, out_add, out_negr, out_negz;
    logic [1:0]    out_rm;
    logic [CW-1:0] count;
    logic          err_illegal;
    logic [15:0]   issued_cnt, stall_cnt;
    logic [3:0]    ctrl_tab [8];
    ent_t          q[$];
    ent_t          last;
    logic          m_err;
    logic [15:0]   m_issued, m_stall;
    int            checks = 0;
    int            errors = 0;

    fma16_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_mul(out_mul), .out_add(out_add), .out_negr(out_negr), .out_negz(out_negz),
        .out_rm(out_rm), .count(count), .err_illegal(err_illegal),
        .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] stat(input logic [15:0] v);
`ifdef FMA16_ISSUE_STATS_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic check_all(input string t);
        ent_t h;
        h = q.size() != 0 ? q[0] : last;
        chk({t, ".count"}, 32'(count), 32'(q.size()));
        chk({t, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({t, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
        chk({t, ".out_x"}, 32'(out_x), 32'(h.x));
        chk({t, ".out_y"}, 32'(out_y), 32'(h.y));
        chk({t, ".out_z"}, 32'(out_z), 32'(h.z));
        chk({t, ".ctrl"}, 32'({out_mul, out_add, out_negr, out_negz}), 32'(h.c));
        chk({t, ".out_rm"}, 32'(out_rm), 32'(h.rm));
        chk({t, ".err"}, 32'(err_illegal), 32'(m_err));
        chk({t, ".issued"}, 32'(issued_cnt), 32'(stat(m_issued)));
        chk({t, ".stall"}, 32'(stall_cnt), 32'(stat(m_stall)));
    endtask

    task automatic tick(input string t);
        bit rdy, vld;
        ent_t e;
        rdy = q.size() < DEPTH;
        vld = q.size() != 0;
        @(posedge clk);
        if (vld && out_ready) begin
            last = q.pop_front();
            m_issued = m_issued + 16'd1;
        end
        if (in_valid && rdy) begin
            if (in_op == 3'd7) m_err = 1;
            else begin
                e.c  = ctrl_tab[in_op];
                e.x  = in_x;
                e.y  = e.c[3] ? in_y : 16'h3C00;
                e.z  = e.c[2] ? in_z : 16'h0000;
                e.rm = in_rm;
                q.push_back(e);
            end
        end
        if (in_valid && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        #1;
        check_all(t);
    endtask

    task automatic do_reset(input string t);
        reset = 1;
        @(posedge clk);
        q.delete();
        last = '{x: 0, y: 0, z: 0, c: 0, rm: 0};
        m_err = 0;
        m_issued = 0;
        m_stall = 0;
        #1;
        reset = 0;
        in_valid = 0;
        check_all(t);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [1:0] rm);
        in_valid = v;
        in_op = op;
        in_x = x;
        in_y = y;
        in_z = z;
        in_rm = rm;
    endtask

    task automatic drive_rand(input logic v, input int max_op);
        drive(v, 3'($urandom_range(0, max_op)), 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
    endtask

    initial begin
        ctrl_tab = '{4'b0100, 4'b0101, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
        repeat (2) @(posedge clk);
        do_reset("reset");
        // 1: fmadd visible the cycle after acceptance
        out_ready = 0;
        drive(1, 3'd3, 16'h3C00, 16'h4000, 16'h4200, 2'b01);
        tick("t1");
        in_valid = 0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_xyz", {out_x, out_y}, 32'h3C004000);
        chk("t1_z", 32'(out_z), 32'h4200);
        chk("t1_ctrl", 32'({out_mul, out_add, out_negr, out_negz}), 32'b1100);
        chk("t1_rm", 32'(out_rm), 32'b01);
        out_ready = 1;
        tick("t1_drain");
        // 2: canonicalisation of unused y and z; empty+enqueue with out_ready=1 does not dequeue
        drive(1, 3'd0, 16'h4000, 16'h7BFF, 16'h3C00, 2'b00);
        tick("t2a");
        in_valid = 0;
        chk("t2a_y", 32'(out_y), 32'h3C00);
        chk("t2a_ctrl", 32'({out_mul, out_add, out_negr, out_negz}), 32'b0100);
        tick("t2a_drain");
        drive(1, 3'd2, 16'h4400, 16'h4200, 16'h4500, 2'b10);
        tick("t2b");
        in_valid = 0;
        chk("t2b_z", 32'(out_z), 32'h0000);
        chk("t2b_ctrl", 32'({out_mul, out_add, out_negr, out_negz}), 32'b1000);
        tick("t2b_drain");
        chk("t2b_hold_z", 32'(out_z), 32'h0000);
        // 3: fill, stall on full, then one dequeue frees a slot
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand(1, 6);
            tick("t3_fill");
        end
        chk("t3_ready", 32'(in_ready), 32'd0);
        chk("t3_count", 32'(count), 32'(DEPTH));
        drive_rand(1, 6);
        tick("t3_stall");
        in_valid = 0;
        out_ready = 1;
        tick("t3_pop");
        chk("t3_count3", 32'(count), 32'd3);
        chk("t3_ready1", 32'(in_ready), 32'd1);
        repeat (3) tick("t3_drain");
        // 4: illegal opcode is consumed but dropped
        out_ready = 0;
        drive(1, 3'd7, 16'h1111, 16'h2222, 16'h3333, 2'b11);
        tick("t4_ill");
        drive(1, 3'd1, 16'h4000, 16'h4100, 16'h4200, 2'b01);
        tick("t4_fsub");
        in_valid = 0;
        chk("t4_err", 32'(err_illegal), 32'd1);
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_ctrl", 32'({out_mul, out_add, out_negr, out_negz}), 32'b0101);
        out_ready = 1;
        repeat (3) tick("t4_sticky");
        chk("t4_err_sticky", 32'(err_illegal), 32'd1);
        // 5: streaming, one issue per cycle
        for (int i = 0; i < 20; i++) begin
            drive(1, 3'(i % 7), 16'(i), 16'(i + 100), 16'(i + 200), 2'(i));
            tick("t5_stream");
        end
        chk("t5_count", 32'(count), 32'd1);
        in_valid = 0;
        tick("t5_drain");
        // 6: reset mid-operation discards buffered entries
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(1, 6);
            tick("t6_fill");
        end
        out_ready = 1;
        do_reset("t6_reset");
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_x", 32'(out_x), 32'd0);
        repeat (4) tick("t6_after");
        // randomized traffic including illegal opcodes
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom_range(0, 1)), 7);
            out_ready = 1'($urandom_range(0, 2) != 0);
            tick("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
